// File: rtl/disk_upload_pkg.sv
// disk_upload_pkg
// Shared definitions for the floppy image upload path: the SDRAM base of the
// FDD buffer region, the upload FSM state encoding and the address helper.
// Also used by the top-level sram address mux.
package disk_upload_pkg;

  // SDRAM byte address of floppy image offset 0 (FDD buffer region).
  localparam logic [24:0] FDD_BASE = 25'h0500000;

  // Upload FSM state encoding.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_REQ   = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_HOLD  = 3'd3;
  localparam state_t ST_FLUSH = 3'd4;
  localparam state_t ST_DRAIN = 3'd5;

  // SDRAM address of an image offset (offset already zero-extended).
  // The 25-bit sum wraps modulo 2^25.
  function automatic logic [24:0] fdd_addr(input logic [24:0] base,
                                           input logic [24:0] off);
    return base + off;
  endfunction

endpackage

// File: rtl/disk_upload_byte_fifo2.sv
// byte_fifo2
// Two-entry, 8-bit FIFO with a registered head. Push and pop in the same cycle
// are legal at any fill level that allows the pop, including full.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush          : synchronous clear of all contents
//   push, din, full: write side
//   pop, dout, empty: read side; dout is the head entry
module byte_fifo2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] din,
  output logic       full,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty
);

  logic [7:0] head_r;
  logic [7:0] tail_r;
  logic [1:0] cnt_r;
  logic       do_pop_s;
  logic       do_push_s;

  // A pop frees the slot a same-cycle push needs when the FIFO is full.
  assign do_pop_s  = pop & (cnt_r != 2'd0);
  assign do_push_s = push & ((cnt_r != 2'd2) | do_pop_s);

  assign full  = (cnt_r == 2'd2);
  assign empty = (cnt_r == 2'd0);
  assign dout  = head_r;

  // Storage and fill count; head always holds the oldest entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r <= 8'h00;
      tail_r <= 8'h00;
      cnt_r  <= 2'd0;
    end else if (flush) begin
      head_r <= 8'h00;
      tail_r <= 8'h00;
      cnt_r  <= 2'd0;
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10: begin
          if (cnt_r == 2'd0) begin
            head_r <= din;
          end else begin
            tail_r <= din;
          end
          cnt_r <= cnt_r + 2'd1;
        end
        2'b01: begin
          head_r <= tail_r;
          cnt_r  <= cnt_r - 2'd1;
        end
        2'b11: begin
          // Count unchanged; with one entry the new byte becomes the head.
          if (cnt_r == 2'd1) begin
            head_r <= din;
          end else begin
            head_r <= tail_r;
            tail_r <= din;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: rtl/disk_upload.sv
// disk_upload
// Streams the floppy image held in SDRAM back to the ARM side byte by byte.
// Reads are issued one at a time on the sram misc port; returned bytes go
// through a 2-entry FIFO to a valid/ready stream carrying the image offset.
// Ports:
//   clk_sys, rst_n          : clock, asynchronous active-low reset
//   start, length, abort    : control; length sampled on an accepted start
//   busy, done              : status; done is a one-cycle completion pulse
//   misc_addr, misc_rd      : sram read request (held until misc_ready)
//   misc_dout, misc_ready   : sram read data, valid on the misc_ready pulse
//   up_data, up_valid,
//   up_ready, up_offset     : byte stream to the upload serializer
module disk_upload
  import disk_upload_pkg::*;
#(
  parameter logic [24:0] BASE  = FDD_BASE,
  parameter int          LEN_W = 20
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] length,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [24:0]      misc_addr,
  output logic             misc_rd,
  input  logic [7:0]       misc_dout,
  input  logic             misc_ready,
  output logic [7:0]       up_data,
  output logic             up_valid,
  input  logic             up_ready,
  output logic [LEN_W-1:0] up_offset
);

  localparam logic [LEN_W-1:0] OFF_ONE = LEN_W'(1);

  state_t           state_r;
  state_t           next_s;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] rd_off_r;
  logic [LEN_W-1:0] tx_off_r;
  logic [LEN_W-1:0] rd_inc_s;
  logic             busy_r;
  logic             done_r;
  logic             misc_rd_r;
  logic [24:0]      misc_addr_r;
  logic             push_s;
  logic             pop_s;
  logic             load_s;
  logic             fifo_flush_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             zero_done_s;
  logic             end_done_s;

  assign rd_inc_s = rd_off_r + OFF_ONE;
  assign push_s   = (state_r == ST_WAIT) & misc_ready & ~abort;
  assign pop_s    = up_ready & ~fifo_empty_s;
  assign load_s   = (state_r == ST_IDLE) & (next_s == ST_REQ);

  byte_fifo2 u_fifo (
    .clk   (clk_sys),
    .rst_n (rst_n),
    .flush (fifo_flush_s),
    .push  (push_s),
    .din   (misc_dout),
    .full  (fifo_full_s),
    .pop   (pop_s),
    .dout  (up_data),
    .empty (fifo_empty_s)
  );

  // Next-state decode, FIFO flush on abort and the two done sources.
  always_comb begin
    next_s       = state_r;
    fifo_flush_s = 1'b0;
    zero_done_s  = 1'b0;
    end_done_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // FIFO is empty here, so the first read always has a slot.
        if (start && !abort) begin
          if (length != '0) begin
            next_s = ST_REQ;
          end else begin
            zero_done_s = 1'b1;
          end
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (abort) begin
          next_s       = ST_IDLE;
          fifo_flush_s = 1'b1;
        end else begin
          next_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          // The read in flight must complete before going idle.
          fifo_flush_s = 1'b1;
          if (misc_ready) begin
            next_s = ST_IDLE;
          end else begin
            next_s = ST_DRAIN;
          end
        end else if (misc_ready) begin
          // Before this push at most one entry is held, so after it a slot
          // is free exactly when the FIFO was empty or pops this cycle.
          if (rd_inc_s == len_r) begin
            next_s = ST_FLUSH;
          end else if (fifo_empty_s || pop_s) begin
            next_s = ST_REQ;
          end else begin
            next_s = ST_HOLD;
          end
        end else begin
          next_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          next_s       = ST_IDLE;
          fifo_flush_s = 1'b1;
        end else if (!fifo_full_s || pop_s) begin
          next_s = ST_REQ;
        end else begin
          next_s = ST_HOLD;
        end
      end
      ST_FLUSH: begin
        // Finish on the cycle the last byte is accepted.
        if (abort) begin
          next_s       = ST_IDLE;
          fifo_flush_s = 1'b1;
        end else if (fifo_empty_s || (pop_s && !fifo_full_s)) begin
          next_s     = ST_IDLE;
          end_done_s = 1'b1;
        end else begin
          next_s = ST_FLUSH;
        end
      end
      ST_DRAIN: begin
        if (misc_ready) begin
          next_s = ST_IDLE;
        end else begin
          next_s = ST_DRAIN;
        end
      end
      default: begin
        next_s       = ST_IDLE;
        fifo_flush_s = 1'b1;
      end
    endcase
  end

  // FSM state and registered status/request outputs derived from next state.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      misc_rd_r <= 1'b0;
    end else begin
      state_r   <= next_s;
      busy_r    <= (next_s != ST_IDLE);
      done_r    <= zero_done_s | end_done_s;
      misc_rd_r <= (next_s == ST_WAIT) | (next_s == ST_DRAIN);
    end
  end

  // Read address is registered in REQ and held through WAIT/DRAIN.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      misc_addr_r <= 25'h0000000;
    end else if (state_r == ST_REQ) begin
      misc_addr_r <= fdd_addr(BASE, 25'(rd_off_r));
    end else begin
      misc_addr_r <= misc_addr_r;
    end
  end

  // Length latch plus read and transmit offset counters.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      len_r    <= '0;
      rd_off_r <= '0;
      tx_off_r <= '0;
    end else if (load_s) begin
      len_r    <= length;
      rd_off_r <= '0;
      tx_off_r <= '0;
    end else begin
      if (push_s) begin
        rd_off_r <= rd_inc_s;
      end
      if (pop_s) begin
        tx_off_r <= tx_off_r + OFF_ONE;
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign misc_rd   = misc_rd_r;
  assign misc_addr = misc_addr_r;
  assign up_valid  = ~fifo_empty_s;
  assign up_offset = tx_off_r;

endmodule

// File: tb/tb_disk_upload.sv
`timescale 1ns/1ps
module tb_disk_upload;
  import disk_upload_pkg::*;

  localparam int          LEN_W = 20;
  localparam logic [24:0] BASE  = FDD_BASE;

  logic             clk_sys = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] length = '0;
  logic             abort = 1'b0;
  logic             busy;
  logic             done;
  logic [24:0]      misc_addr;
  logic             misc_rd;
  logic [7:0]       misc_dout = 8'h00;
  logic             misc_ready = 1'b0;
  logic [7:0]       up_data;
  logic             up_valid;
  logic             up_ready = 1'b0;
  logic [LEN_W-1:0] up_offset;

  int checks = 0;
  int errors = 0;

  // Behavioural image in SDRAM and environment knobs.
  logic [7:0] image [0:255];
  int sram_lat = 3;
  int ready_hold = 0;
  bit rand_ready = 1'b0;

  // Observations gathered by the monitor.
  int         cyc = 0;
  logic [7:0] got_data [$];
  int         got_off [$];
  int         addr_q [$];
  int done_cnt = 0, done_cyc = -1, last_pop_cyc = -1, rd_starts = 0;
  int first_rd_cyc = -1, start_cyc = -1, resp_cnt = 0;
  bit busy_seen = 1'b0, valid_seen = 1'b0, busy_at_done = 1'b0, rd_prev = 1'b0;

  always #5 clk_sys = ~clk_sys;

  disk_upload #(.BASE(BASE), .LEN_W(LEN_W)) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .start      (start),
    .length     (length),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .misc_addr  (misc_addr),
    .misc_rd    (misc_rd),
    .misc_dout  (misc_dout),
    .misc_ready (misc_ready),
    .up_data    (up_data),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_offset  (up_offset)
  );

  // sram: answers a held read sram_lat cycles after it first appears.
  initial begin : sram_model
    int age;
    logic [24:0] rel;
    age = 0;
    forever begin
      @(posedge clk_sys); #2;
      if (!rst_n) begin
        misc_ready = 1'b0; age = 0;
      end else if (misc_ready) begin
        misc_ready = 1'b0; age = 0;
      end else if (misc_rd) begin
        age++;
        if (age > sram_lat) begin
          rel = misc_addr - BASE;
          misc_dout  = image[rel[7:0]];
          misc_ready = 1'b1;
          addr_q.push_back(int'(misc_addr));
          resp_cnt++;
          age = 0;
        end
      end else begin
        age = 0;
      end
    end
  end

  // Consumer: held low for ready_hold cycles, else random or always ready.
  initial begin : consumer
    forever begin
      @(posedge clk_sys); #2;
      if (ready_hold > 0) begin
        up_ready = 1'b0; ready_hold--;
      end else if (rand_ready) begin
        up_ready = 1'($urandom_range(0, 1));
      end else begin
        up_ready = 1'b1;
      end
    end
  end

  // Monitor sampled mid-cycle.
  initial begin : monitor
    forever begin
      @(negedge clk_sys);
      if (up_valid && up_ready) begin
        got_data.push_back(up_data);
        got_off.push_back(int'(up_offset));
        last_pop_cyc = cyc;
      end
      if (up_valid) valid_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
      if (done) begin done_cnt++; done_cyc = cyc; busy_at_done = busy; end
      if (misc_rd && !rd_prev) begin
        rd_starts++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      rd_prev = misc_rd;
      if (start) start_cyc = cyc;
      cyc++;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    got_data.delete(); got_off.delete(); addr_q.delete();
    done_cnt = 0; done_cyc = -1; last_pop_cyc = -1; rd_starts = 0;
    first_rd_cyc = -1; start_cyc = -1; resp_cnt = 0;
    busy_seen = 1'b0; valid_seen = 1'b0; busy_at_done = 1'b0;
  endtask

  task automatic pulse_start(input int len);
    @(posedge clk_sys); #2;
    length = LEN_W'(len); start = 1'b1;
    @(posedge clk_sys); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_sys); #1;
      if (done_cnt > 0) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_sys); #1;
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk_sys); #1;
    checks++;
    if ({busy, done, misc_rd, up_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {busy, done, misc_rd, up_valid});
    end
    checks++;
    if (misc_addr !== 25'h0 || up_data !== 8'h00 || up_offset !== '0) begin
      errors++; $display("FAIL reset_buses addr %h data %h off %0d exp 0", misc_addr, up_data, up_offset);
    end
    @(posedge clk_sys); #2; rst_n = 1'b1;
    repeat (2) @(posedge clk_sys);
  endtask

  task automatic test_basic();
    bit ok;
    sram_lat = 3; rand_ready = 1'b0; ready_hold = 0;
    for (int k = 0; k < 4; k++) image[k] = 8'(8'hA0 + k);
    clear_mon();
    pulse_start(4);
    wait_done(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout done %0d exp 1", done_cnt); end
    checks++;
    if (got_data.size() != 4) begin errors++; $display("FAIL basic_count got %0d exp 4", got_data.size()); end
    for (int k = 0; k < got_data.size() && k < 4; k++) begin
      checks++;
      if (got_data[k] !== 8'(8'hA0 + k) || got_off[k] != k) begin
        errors++; $display("FAIL basic_byte[%0d] got %h@%0d exp %h@%0d", k, got_data[k], got_off[k], 8'(8'hA0 + k), k);
      end
    end
    for (int k = 0; k < addr_q.size() && k < 4; k++) begin
      checks++;
      if (addr_q[k] != 32'h500000 + k) begin
        errors++; $display("FAIL basic_addr[%0d] got %h exp %h", k, addr_q[k], 32'h500000 + k);
      end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", done_cnt); end
    checks++;
    if (done_cyc != last_pop_cyc + 1) begin
      errors++; $display("FAIL basic_done_latency got %0d exp %0d", done_cyc - last_pop_cyc, 1);
    end
    checks++;
    if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b exp 0", busy_at_done); end
    checks++;
    if (first_rd_cyc - start_cyc != 2) begin
      errors++; $display("FAIL basic_start_to_rd got %0d exp 2", first_rd_cyc - start_cyc);
    end
  endtask

  task automatic test_back_pressure();
    bit ok;
    sram_lat = 3; rand_ready = 1'b0;
    for (int k = 0; k < 6; k++) image[k] = 8'($urandom);
    clear_mon();
    ready_hold = 22;
    pulse_start(6);
    repeat (15) @(negedge clk_sys); #1;
    checks++;
    if (rd_starts != 2 || misc_rd !== 1'b0 || up_valid !== 1'b1) begin
      errors++; $display("FAIL bp_stall reads %0d rd %b valid %b exp 2 0 1", rd_starts, misc_rd, up_valid);
    end
    repeat (3) @(negedge clk_sys); #1;
    checks++;
    if (rd_starts != 2 || got_data.size() != 0) begin
      errors++; $display("FAIL bp_still_stalled reads %0d pops %0d exp 2 0", rd_starts, got_data.size());
    end
    wait_done(400, ok);
    checks++;
    if (!ok || got_data.size() != 6) begin
      errors++; $display("FAIL bp_complete done %b bytes %0d exp 1 6", ok, got_data.size());
    end
    for (int k = 0; k < got_data.size() && k < 6; k++) begin
      checks++;
      if (got_data[k] !== image[k] || got_off[k] != k) begin
        errors++; $display("FAIL bp_byte[%0d] got %h@%0d exp %h@%0d", k, got_data[k], got_off[k], image[k], k);
      end
    end
  endtask

  task automatic test_zero_length();
    clear_mon(); ready_hold = 0;
    pulse_start(0);
    repeat (5) @(negedge clk_sys); #1;
    checks++;
    if (done_cnt != 1 || done_cyc != start_cyc + 1) begin
      errors++; $display("FAIL zero_done count %0d latency %0d exp 1 1", done_cnt, done_cyc - start_cyc);
    end
    checks++;
    if (rd_starts != 0 || busy_seen) begin
      errors++; $display("FAIL zero_quiet reads %0d busy_seen %b exp 0 0", rd_starts, busy_seen);
    end
  endtask

  task automatic test_abort_wait();
    bit ok;
    sram_lat = 6; ready_hold = 0;
    clear_mon();
    pulse_start(3);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys); #1;
      if (misc_rd) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL abw_no_read got 0 exp 1"); end
    @(posedge clk_sys); #2; abort = 1'b1;
    @(posedge clk_sys); #2; abort = 1'b0;
    @(negedge clk_sys); #1;
    checks++;
    if (misc_rd !== 1'b1 || resp_cnt != 0) begin
      errors++; $display("FAIL abw_held rd %b resp %0d exp 1 0", misc_rd, resp_cnt);
    end
    wait_idle(40, ok);
    repeat (3) @(negedge clk_sys); #1;
    checks++;
    if (!ok || resp_cnt != 1 || misc_rd !== 1'b0) begin
      errors++; $display("FAIL abw_drain idle %b resp %0d rd %b exp 1 1 0", ok, resp_cnt, misc_rd);
    end
    checks++;
    if (valid_seen || done_cnt != 0 || rd_starts != 1) begin
      errors++; $display("FAIL abw_discard valid %b done %0d reads %0d exp 0 0 1", valid_seen, done_cnt, rd_starts);
    end
  endtask

  task automatic test_abort_hold();
    clear_mon(); sram_lat = 2; ready_hold = 0;
    @(posedge clk_sys); #2; length = LEN_W'(5); start = 1'b1; abort = 1'b1;
    @(posedge clk_sys); #2; start = 1'b0; abort = 1'b0;
    repeat (4) @(negedge clk_sys); #1;
    checks++;
    if (busy_seen || done_cnt != 0 || rd_starts != 0) begin
      errors++; $display("FAIL abort_wins busy %b done %0d reads %0d exp 0 0 0", busy_seen, done_cnt, rd_starts);
    end
    clear_mon();
    ready_hold = 30;
    pulse_start(8);
    repeat (14) @(negedge clk_sys);
    @(posedge clk_sys); #2; abort = 1'b1;
    @(posedge clk_sys); #2; abort = 1'b0;
    @(negedge clk_sys); #1;
    checks++;
    if (busy !== 1'b0 || up_valid !== 1'b0 || misc_rd !== 1'b0) begin
      errors++; $display("FAIL abh_idle busy %b valid %b rd %b exp 0 0 0", busy, up_valid, misc_rd);
    end
    repeat (20) @(negedge clk_sys); #1;
    checks++;
    if (done_cnt != 0 || rd_starts != 2 || got_data.size() != 0) begin
      errors++; $display("FAIL abh_after done %0d reads %0d pops %0d exp 0 2 0", done_cnt, rd_starts, got_data.size());
    end
    ready_hold = 0;
    repeat (12) @(posedge clk_sys);
  endtask

  task automatic test_reset_restart();
    bit ok;
    sram_lat = 2; rand_ready = 1'b0; ready_hold = 0;
    for (int k = 0; k < 8; k++) image[k] = 8'($urandom);
    clear_mon();
    pulse_start(8);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_sys); #1;
      if (got_data.size() >= 2) begin ok = 1'b1; break; end
    end
    @(posedge clk_sys); #2; rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || {busy, done, misc_rd, up_valid} !== 4'b0000 || up_offset !== '0 || misc_addr !== 25'h0) begin
      errors++; $display("FAIL rst_mid reached %b flags %b off %0d addr %h exp 1 0000 0 0",
                         ok, {busy, done, misc_rd, up_valid}, up_offset, misc_addr);
    end
    repeat (2) @(posedge clk_sys); #2; rst_n = 1'b1;
    repeat (2) @(posedge clk_sys);
    clear_mon();
    pulse_start(2);
    wait_done(100, ok);
    checks++;
    if (!ok || got_data.size() != 2 || done_cnt != 1) begin
      errors++; $display("FAIL rst_restart done %0d bytes %0d exp 1 2", done_cnt, got_data.size());
    end
    for (int k = 0; k < got_data.size() && k < 2; k++) begin
      checks++;
      if (got_data[k] !== image[k] || got_off[k] != k) begin
        errors++; $display("FAIL rst_byte[%0d] got %h@%0d exp %h@%0d", k, got_data[k], got_off[k], image[k], k);
      end
    end
  endtask

  task automatic test_start_busy();
    bit ok;
    sram_lat = 1; ready_hold = 0;
    for (int k = 0; k < 12; k++) image[k] = 8'($urandom);
    clear_mon();
    pulse_start(5);
    repeat (4) @(posedge clk_sys);
    pulse_start(9);
    wait_done(200, ok);
    repeat (20) @(negedge clk_sys); #1;
    checks++;
    if (!ok || got_data.size() != 5 || done_cnt != 1 || rd_starts != 5) begin
      errors++; $display("FAIL sb_len bytes %0d done %0d reads %0d exp 5 1 5", got_data.size(), done_cnt, rd_starts);
    end
    for (int k = 0; k < got_data.size() && k < 5; k++) begin
      checks++;
      if (got_data[k] !== image[k] || got_off[k] != k) begin
        errors++; $display("FAIL sb_byte[%0d] got %h@%0d exp %h@%0d", k, got_data[k], got_off[k], image[k], k);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int len;
    for (int it = 0; it < 8; it++) begin
      len = $urandom_range(1, 12);
      sram_lat = $urandom_range(0, 4);
      rand_ready = 1'b1; ready_hold = 0;
      for (int k = 0; k < 16; k++) image[k] = 8'($urandom);
      clear_mon();
      pulse_start(len);
      wait_done(80 * len + 50, ok);
      checks++;
      if (!ok || got_data.size() != len || done_cnt != 1) begin
        errors++; $display("FAIL rnd%0d_len done %0d bytes %0d exp 1 %0d", it, done_cnt, got_data.size(), len);
      end
      for (int k = 0; k < got_data.size() && k < len; k++) begin
        checks++;
        if (got_data[k] !== image[k] || got_off[k] != k) begin
          errors++; $display("FAIL rnd%0d_byte[%0d] got %h@%0d exp %h@%0d", it, k, got_data[k], got_off[k], image[k], k);
        end
      end
      for (int k = 0; k < addr_q.size(); k++) begin
        checks++;
        if (addr_q[k] != int'(BASE) + k) begin
          errors++; $display("FAIL rnd%0d_addr[%0d] got %h exp %h", it, k, addr_q[k], int'(BASE) + k);
        end
      end
    end
    rand_ready = 1'b0;
  endtask

  initial begin : main
    for (int k = 0; k < 256; k++) image[k] = 8'h00;
    test_reset();
    test_basic();
    test_back_pressure();
    test_zero_length();
    test_abort_wait();
    test_abort_hold();
    test_reset_restart();
    test_start_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/disk_upload.md
# disk_upload

Streams the floppy image held in SDRAM back out to the ARM side, byte by byte. It is the reverse of the download path, which writes the disk image into SDRAM. It issues reads on the sram `misc_*` port, which the download path leaves without a reader, and buffers the returned bytes in a 2-entry FIFO. A valid/ready byte stream carries them to the upload serializer. Writes made through the WD1793 buffer can then be saved from the host.

## Interface
- `BASE`, 25'h0500000: SDRAM byte address of image offset 0 (FDD buffer region).
- `LEN_W`, 20: width of the length and offset counters.
- `clk_sys`, in, 1: system clock; all logic on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: one-cycle pulse that begins an upload; ignored while `busy`.
- `length`, in, LEN_W: byte count, sampled on `start`.
- `abort`, in, 1: one-cycle pulse that cancels an upload in progress.
- `busy`, out, 1: high from the accepted `start` until return to IDLE.
- `done`, out, 1: one-cycle pulse when the upload completes.
- `misc_addr`, out, 25: SDRAM read address.
- `misc_rd`, out, 1: read request level.
- `misc_dout`, in, 8: read data from sram.
- `misc_ready`, in, 1: one-cycle pulse; `misc_dout` is valid in the same cycle.
- `up_data`, out, 8: stream byte (FIFO head).
- `up_valid`, out, 1: `up_data` is valid.
- `up_ready`, in, 1: consumer accepts the byte on a cycle where valid & ready.
- `up_offset`, out, LEN_W: image offset of the current `up_data`.

## Operation
- Reset values: all outputs are 0, state is IDLE, FIFO is empty, counters are 0.
- IDLE
  - On `start` with `length` != 0: latch `len`, clear `rd_off` and `tx_off`, and go to REQ.
  - On `start` with `length` == 0: pulse `done` on the next cycle and stay in IDLE; `busy` stays low.
- REQ
  - Enter only when the FIFO has a free slot, counting the outstanding read.
  - Drive `misc_addr` = BASE + `rd_off` and assert `misc_rd`, then go to WAIT.
- WAIT
  - Hold `misc_rd` and `misc_addr` stable until `misc_ready`.
  - On `misc_ready`: push `misc_dout` into the FIFO, drop `misc_rd` in the next cycle, and increment `rd_off`.
  - Then, if `rd_off` == `len`, go to FLUSH. Otherwise, if the FIFO has space, go to REQ; otherwise go to HOLD.
- HOLD: wait for FIFO space, then go to REQ.
- FLUSH
  - Wait until the FIFO is empty, i.e. the last byte has been accepted.
  - Then pulse `done` for one cycle and go to IDLE.
- Stream side
  - `up_valid` = FIFO not empty.
  - A pop happens on `up_valid & up_ready`; each pop increments `tx_off`, and `up_offset` = `tx_off`.
- Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- abort
  - In REQ, HOLD or FLUSH: flush the FIFO and go to IDLE next cycle; `done` is not pulsed.
  - In WAIT: go to DRAIN. DRAIN keeps `misc_rd` high until `misc_ready`, discards the data, then goes to IDLE.
  - Abort never leaves an sram request half-issued.
- `start` and `abort` in the same cycle: abort wins; `start` is ignored.
- Widths
  - Offsets are LEN_W unsigned. `length` = 2^LEN_W − 1 is the maximum; there is no wrap.
  - Address sum is BASE + zero-extended offset, modulo 2^25.

## Timing
- `start` to first `misc_rd` high: 2 cycles (IDLE→REQ, REQ registers outputs).
- `misc_ready` to `up_valid`: 1 cycle (FIFO registered).
- `misc_ready` to the next `misc_rd`: 2 cycles when the FIFO has space.
- Throughput is bounded by sram latency; the 2-entry FIFO lets the next read overlap consumer stall.
- Last pop to `done`: 1 cycle. `busy` falls in the same cycle `done` rises.
- `rst_n` assertion mid-transfer clears everything asynchronously. sram sees `misc_rd` drop, which the sram tolerates on reset.

## Structure
- Package `disk_upload_pkg`
  - State enum: IDLE, REQ, WAIT, HOLD, FLUSH, DRAIN.
  - Constant `FDD_BASE` = 25'h0500000.
  - Shared by this block and the top-level sram address mux.
- Sub-module `byte_fifo2`
  - 2-deep, 8-bit, registered output.
  - Ports: push/din/full, pop/dout/empty, flush, rst_n.
  - The same FIFO is reusable for the later write-back path.

## Test plan
- Basic transfer: `length`=4, image bytes A0..A3, `up_ready` always 1, sram ready 3 cycles after `misc_rd` -> stream A0,A1,A2,A3 with `up_offset` 0..3; addresses 0x500000..0x500003; single `done`.
- Back-pressure: `length`=6, `up_ready` low for 20 cycles after `start` -> exactly 2 reads issued, then `misc_rd` stays low until the first pop; all 6 bytes arrive in order.
- Zero length: `start` with `length`=0 -> `done` one cycle later; no `misc_rd`; `busy` never high.
- Abort in WAIT: `abort` while `misc_rd` is pending -> `misc_rd` held until `misc_ready`, no push, `up_valid` 0, IDLE; no `done`.
- Reset and restart: `rst_n` low during byte 3 of 8 -> all outputs 0 immediately; after release, `start` with `length`=2 streams offsets 0,1 correctly.
- Start while busy: a second `start` mid-transfer with `length`=9 -> ignored; the original `length`=5 completes with 5 bytes.
